rename_map_table: RTL
=====================

// Module: rename_map_table
// PURPOSE
//  Parametrised register alias table for the rename stage. Maps ARCH_REGS architectural registers to PHYS_W-bit physical tags.
//  Renames LANES instructions per cycle, with intra-group bypass.
//  Holds NCKPT map snapshots in a circular buffer for branch-mispredict recovery.
// PARAMETERS
//  LANES      2   rename lanes per cycle (lane 0 oldest)
//  ARCH_REGS  32  architectural registers; AR_W = $clog2(ARCH_REGS)
//  PHYS_W     6   physical tag width
//  NCKPT      4   checkpoint slots (power of 2); CK_W = $clog2(NCKPT)
//  INIT_IDENT 1   reset map: 1 -> arr[i]=i, 0 -> arr[i]=ARCH_REGS-1-i
// PORTS
//  clk          in   1             clock, rising edge
//  reset        in   1             async, active-low
//  stall        in   1             blocks remap/take/release; restore still acts
//  src_a        in   LANES*AR_W    per-lane source A arch reg
//  src_b        in   LANES*AR_W    per-lane source B arch reg
//  dst          in   LANES*AR_W    per-lane destination arch reg
//  map_a        out  LANES*PHYS_W  tag for src_a (bypassed)
//  map_b        out  LANES*PHYS_W  tag for src_b (bypassed)
//  old_dst      out  LANES*PHYS_W  previous tag of dst (bypassed), to free at commit
//  remap        in   LANES         lane writes new_tag into dst
//  new_tag      in   LANES*PHYS_W  per-lane new physical tag
//  ckpt_take    in   1             snapshot post-update map this cycle
//  ckpt_ack     out  1             comb.: take accepted this cycle
//  ckpt_id      out  CK_W          slot a take uses this cycle (= tail)
//  ckpt_release in   1             free oldest slot (branch resolved correct)
//  ckpt_restore in   1             flush: reload map from slot restore_id
//  restore_id   in   CK_W          slot to restore
//  ckpt_count   out  CK_W+1        live checkpoints
//  ckpt_full    out  1             ckpt_count==NCKPT
//  full_map     out  ARCH_REGS*PHYS_W  current committed-to-arr map, reg i at [i*PHYS_W +: PHYS_W]
// BEHAVIOUR
//  Reset (async, reset==0)
//   - arr per INIT_IDENT; head=tail=0; count=0; snapshot contents don't-care.
//   - Outputs follow: ckpt_count=0, ckpt_full=0, ckpt_id=0.
//  Reads: combinational, zero latency.
//   - Lane k src/dst tag = tag of highest lane j<k with remap[j] and dst[j]==reg; else arr[reg].
//   - Bypass is independent of stall.
//  Update at posedge, priority: restore > stall > normal.
//   - restore: arr <= snap[restore_id]; tail <= restore_id+1 (mod NCKPT).
//     count <= (restore_id-head mod NCKPT)+1; younger slots discarded.
//     Same-cycle remap/take/release ignored. Restore of a non-live id: undefined, bench checks with assertion.
//   - stall (no restore): all state holds; ckpt_ack=0.
//   - normal: each lane with remap sets arr[dst]<=new_tag; same dst in several lanes -> highest lane wins.
//   - take: ckpt_ack = take & !full & !stall & !restore.
//     On ack: snap[tail] <= post-remap map (all lanes of this cycle applied); tail++ ; count++.
//   - release: when count>0, head++ and count--. Ignored when count==0.
//     Release with take at count==NCKPT: full is sampled pre-update, so take is refused and release proceeds.
//   - take+release same cycle (both valid): count unchanged, head and tail both advance.
//  Pointers wrap mod NCKPT. ckpt_full and ckpt_count are registered-state decodes.
//  No X on outputs after reset for any in-range input.
// TESTING
//  1 reset, INIT_IDENT=1 -> full_map reg i == i; src_a=5 -> map_a=5; count=0.
//  2 lane0 remap dst=3 tag=40; lane1 src_a=3 dst=3 remap tag=41.
//    -> lane1 map_a=40, old_dst=40 same cycle; next cycle arr[3]=41.
//  3 take with lane0 remap r7->50 -> ack=1, id=0. Then r7->51; restore id=0.
//    -> arr[7]=50; count=1; tail=1.
//  4 four takes (ack each, ids 0..3) -> full=1; fifth take -> ack=0.
//    take+release at full -> ack=0, count=3.
//  5 stall=1 with remap and take -> arr unchanged, ack=0.
//    stall=1 with restore -> restore applied.
//  6 reset asserted mid-burst (count=2, remaps pending) -> immediate identity map, count=0, without waiting for clk.

Source files
------------

// File: rtl/rename_map_table.sv
// Register alias table for the rename stage: per-lane bypassed lookups,
// per-lane remaps and a circular buffer of map snapshots for mispredict recovery.
module rename_map_table #(
    parameter int LANES      = 2,
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_W     = 6,
    parameter int NCKPT      = 4,
    parameter int INIT_IDENT = 1,
    localparam int AR_W      = $clog2(ARCH_REGS),
    localparam int CK_W      = $clog2(NCKPT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [LANES*AR_W-1:0]         src_a,
    input  logic [LANES*AR_W-1:0]         src_b,
    input  logic [LANES*AR_W-1:0]         dst,
    output logic [LANES*PHYS_W-1:0]       map_a,
    output logic [LANES*PHYS_W-1:0]       map_b,
    output logic [LANES*PHYS_W-1:0]       old_dst,
    input  logic [LANES-1:0]              remap,
    input  logic [LANES*PHYS_W-1:0]       new_tag,
    input  logic                          ckpt_take,
    output logic                          ckpt_ack,
    output logic [CK_W-1:0]               ckpt_id,
    input  logic                          ckpt_release,
    input  logic                          ckpt_restore,
    input  logic [CK_W-1:0]               restore_id,
    output logic [CK_W:0]                 ckpt_count,
    output logic                          ckpt_full,
    output logic [ARCH_REGS*PHYS_W-1:0]   full_map
);

    typedef logic [PHYS_W-1:0] tag_t;

    tag_t            arr_q   [ARCH_REGS];
    tag_t            arr_nxt [ARCH_REGS];
    tag_t            snap_q  [NCKPT][ARCH_REGS];
    logic [CK_W-1:0] head_q;
    logic [CK_W-1:0] tail_q;
    logic [CK_W:0]   count_q;
    logic            take_ok;
    logic            rel_ok;
    logic [CK_W-1:0] rest_dist;

    function automatic tag_t reset_tag(input int i);
        return (INIT_IDENT != 0) ? tag_t'(i) : tag_t'(ARCH_REGS - 1 - i);
    endfunction

    // Lane k sees the newest remap from an older lane in the same group.
    always_comb begin
        logic [AR_W-1:0] ra, rb, rd, wd;
        tag_t            ta, tb, td, nt;
        map_a   = '0;
        map_b   = '0;
        old_dst = '0;
        for (int k = 0; k < LANES; k++) begin
            ra = src_a[k*AR_W +: AR_W];
            rb = src_b[k*AR_W +: AR_W];
            rd = dst[k*AR_W +: AR_W];
            ta = arr_q[ra];
            tb = arr_q[rb];
            td = arr_q[rd];
            for (int j = 0; j < LANES; j++) begin
                wd = dst[j*AR_W +: AR_W];
                nt = new_tag[j*PHYS_W +: PHYS_W];
                if (j < k && remap[j]) begin
                    if (wd == ra) ta = nt;
                    if (wd == rb) tb = nt;
                    if (wd == rd) td = nt;
                end
            end
            map_a[k*PHYS_W +: PHYS_W]   = ta;
            map_b[k*PHYS_W +: PHYS_W]   = tb;
            old_dst[k*PHYS_W +: PHYS_W] = td;
        end
    end

    // Post-remap map; ascending lane order lets the youngest writer win.
    always_comb begin
        arr_nxt = arr_q;
        for (int k = 0; k < LANES; k++) begin
            if (remap[k]) arr_nxt[dst[k*AR_W +: AR_W]] = new_tag[k*PHYS_W +: PHYS_W];
        end
    end

    // ckpt_take is a request; ckpt_ack says it was accepted this cycle into slot ckpt_id.
    assign ckpt_full  = (count_q == (CK_W+1)'(NCKPT));
    assign take_ok    = ckpt_take & ~ckpt_full & ~stall & ~ckpt_restore;
    assign rel_ok     = ckpt_release & (count_q != '0) & ~stall & ~ckpt_restore;
    assign ckpt_ack   = take_ok;
    assign ckpt_id    = tail_q;
    assign ckpt_count = count_q;
    assign rest_dist  = restore_id - head_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REGS; i++) arr_q[i] <= reset_tag(i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (ckpt_restore) begin
            arr_q   <= snap_q[restore_id];
            tail_q  <= restore_id + CK_W'(1);
            count_q <= (CK_W+1)'(rest_dist) + (CK_W+1)'(1);
        end else if (!stall) begin
            arr_q   <= arr_nxt;
            if (take_ok) tail_q <= tail_q + CK_W'(1);
            if (rel_ok)  head_q <= head_q + CK_W'(1);
            count_q <= count_q + (CK_W+1)'(take_ok) - (CK_W+1)'(rel_ok);
        end
    end

    // Snapshot storage carries no reset: contents are only meaningful once taken.
    always_ff @(posedge clk) begin
        if (take_ok) snap_q[tail_q] <= arr_nxt;
    end

    for (genvar i = 0; i < ARCH_REGS; i++) begin : g_pack
        assign full_map[i*PHYS_W +: PHYS_W] = arr_q[i];
    end

endmodule
